clkdiv: RTL and testbench
=========================

CLKDIV -- requirements
Module: clkdiv

Interface
REQ-001 The block SHALL have parameter STAGES, default 4, meaning the number of divided clock outputs; legal range 1..16.
REQ-002 The block SHALL have port clkin, input, 1 bit: the single source clock; all state is updated on its rising edge only.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high, sampled on rising clkin.
REQ-004 The block SHALL have port clkout, output, STAGES bits: bit i is clkin divided by 2^(i+1).

Function
REQ-005 The block SHALL hold an internal STAGES-bit binary up-counter clocked by rising clkin.
REQ-006 Each rising clkin edge with rst=0 SHALL increment the counter by 1, modulo 2^STAGES.
REQ-007 At count 2^STAGES-1, the next edge SHALL wrap the counter to 0 with no stall or extra cycle.
REQ-008 clkout[i] SHALL equal counter bit i, driven directly from a flop with no combinational logic after it, so outputs are glitch-free.
REQ-009 clkout[i] SHALL have period 2^(i+1) clkin periods and exactly 50% duty cycle.
REQ-010 All clkout bits SHALL change only on rising clkin, within the same clock-to-q delay, and SHALL NOT change between edges.
REQ-011 Every rising edge of clkout[i], i>0, SHALL coincide with a falling edge of every clkout[j], j<i.
REQ-012 Consequence of REQ-011: at a rising edge of clkout[STAGES-1], all lower bits SHALL go to 0, giving the phase alignment a tree deserializer needs.
REQ-013 Latency: the first rising clkin edge after rst deasserts SHALL set clkout to 1.
REQ-014 clkout[i] SHALL first rise on the 2^i-th rising clkin edge after reset release.
REQ-015 With STAGES=1, the block SHALL reduce to a single toggle flop: clkout[0] toggles on every rising clkin edge.
REQ-016 The block SHALL contain no latches, no derived clocks driving internal logic, and no asynchronous paths.

Reset
REQ-017 While rst=1 at a rising clkin edge, the counter SHALL load 0, so all clkout bits are 0 after that edge.
REQ-018 rst SHALL take priority over increment.
REQ-019 Before the first rising clkin edge with rst=1, clkout SHALL be treated as unknown.
REQ-020 Asserting rst mid-count SHALL force clkout to 0 on the next rising clkin edge, regardless of the current count.
REQ-021 After a mid-count reset, counting SHALL restart from 0 exactly as after power-up.
REQ-022 If rst deasserts and then reasserts after one clkin cycle, clkout SHALL be 1 for one cycle, then 0.

Verification
REQ-023 Reset hold: STAGES=4, rst=1 for 5 clkin edges -> clkout=0000 after the first of those edges and through all 5.
REQ-024 Count sequence: release rst -> after edges 1,2,3 clkout=0001,0010,0011; after edge 15 it is 1111; after edge 16 it is 0000.
REQ-025 Frequency and duty: run 64 clkin cycles after release -> clkout[0] period 2 cycles, clkout[3] period 16 cycles, each high exactly half its period.
REQ-026 Edge alignment: at every rising edge of clkout[3], clkout[2:0] transitions to 000 on the same clkin edge.
REQ-027 Mid-count reset: assert rst when clkout=1011 -> clkout=0000 on the next edge; release -> 0001 one edge later.
REQ-028 Minimum configuration: STAGES=1 with rst released -> clkout alternates 1,0,1,0 on successive rising clkin edges.

Source files
------------

// File: rtl/clkdiv.sv
// clkdiv: binary ripple-free clock divider.
// A single STAGES-bit up-counter runs on clkin; clkout[i] is counter bit i,
// i.e. clkin divided by 2^(i+1) with 50% duty cycle. Because all outputs come
// straight from counter flops, they change together on rising clkin and a
// rising edge of any bit coincides with all lower bits falling to 0.
//
// Ports:
//   clkin  - source clock, all state updates on its rising edge
//   rst    - synchronous active-high reset, clears the counter
//   clkout - STAGES divided clocks, bit i = clkin / 2^(i+1)
module clkdiv #(
  parameter int unsigned STAGES = 4
) (
  input  logic              clkin,
  input  logic              rst,
  output logic [STAGES-1:0] clkout
);

  logic [STAGES-1:0] cnt_q;
  logic [STAGES-1:0] cnt_d;

  // Natural wrap of the STAGES-bit add gives the modulo-2^STAGES roll-over.
  always_comb begin
    cnt_d = cnt_q + STAGES'(1);
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Outputs taken directly from the flops so they are glitch-free.
  assign clkout = cnt_q;

endmodule

// File: tb/tb_clkdiv.sv
module tb_clkdiv;

  logic       clkin;
  logic       rst;
  logic       rst1;
  logic [3:0] clkout;
  logic [0:0] clkout1;

  int checks;
  int failures;

  clkdiv #(.STAGES(4)) dut (
    .clkin  (clkin),
    .rst    (rst),
    .clkout (clkout)
  );

  clkdiv #(.STAGES(1)) dut1 (
    .clkin  (clkin),
    .rst    (rst1),
    .clkout (clkout1)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  typedef struct {
    bit         rst_in;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input bit r);
    @(negedge clkin);
    rst = r;
    @(posedge clkin);
    #1;
  endtask

  task automatic step1(input bit r);
    @(negedge clkin);
    rst1 = r;
    @(posedge clkin);
    #1;
  endtask

  int         model;
  logic [3:0] prev;
  logic [3:0] hist[64];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rst1     = 1'b1;

    // Reset hold for 5 edges, then 16 counting edges including the wrap.
    for (int k = 0; k < 5; k++) vecs.push_back('{1'b1, 4'd0});
    for (int k = 1; k <= 16; k++) vecs.push_back('{1'b0, 4'(k % 16)});
    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst_in);
      chk($sformatf("table[%0d]", k), int'(clkout), int'(vecs[k].exp));
    end

    // Mid-count reset at 1011.
    for (int k = 0; k < 11; k++) step(1'b0);
    chk("reach_1011", int'(clkout), 11);
    step(1'b1);
    chk("midreset_clear", int'(clkout), 0);
    step(1'b0);
    chk("midreset_restart", int'(clkout), 1);
    step(1'b0);
    chk("midreset_second", int'(clkout), 2);

    // Release for a single cycle then reassert.
    step(1'b1);
    chk("pulse_pre", int'(clkout), 0);
    step(1'b0);
    chk("pulse_one", int'(clkout), 1);
    step(1'b1);
    chk("pulse_back", int'(clkout), 0);

    // Frequency, duty and first-rise latency over 64 cycles after release.
    for (int k = 0; k < 64; k++) begin
      step(1'b0);
      hist[k] = clkout;
    end
    for (int i = 0; i < 4; i++) begin
      int first_rise;
      int last_rise;
      int rises;
      int bad_period;
      int highs;
      first_rise = -1;
      last_rise  = -1;
      rises      = 0;
      bad_period = 0;
      highs      = 0;
      for (int k = 0; k < 64; k++) begin
        bit pv;
        pv = (k == 0) ? 1'b0 : hist[k-1][i];
        if (hist[k][i]) highs++;
        if (hist[k][i] && !pv) begin
          if (first_rise < 0) first_rise = k + 1;
          if (last_rise >= 0 && (k - last_rise) != (1 << (i + 1))) bad_period++;
          last_rise = k;
          rises++;
        end
      end
      chk($sformatf("first_rise[%0d]", i), first_rise, 1 << i);
      chk($sformatf("period_err[%0d]", i), bad_period, 0);
      chk($sformatf("rise_count[%0d]", i), rises, 64 >> (i + 1));
      chk($sformatf("high_cycles[%0d]", i), highs, 32);
    end

    // Randomized run against an arithmetic model, with edge-alignment checks.
    step(1'b1);
    model = 0;
    prev  = clkout;
    for (int k = 0; k < 400; k++) begin
      bit r;
      r = ($urandom_range(0, 24) == 0);
      step(r);
      model = r ? 0 : (model + 1) % 16;
      chk("rand_count", int'(clkout), model);
      if (!prev[3] && clkout[3]) begin
        chk("align_low_bits", int'(clkout[2:0]), 0);
        chk("align_prev_bits", int'(prev[2:0]), 7);
      end
      prev = clkout;
    end

    // Minimum configuration toggles every edge.
    step1(1'b1);
    chk("s1_reset", int'(clkout1), 0);
    for (int k = 1; k <= 6; k++) begin
      step1(1'b0);
      chk($sformatf("s1_toggle[%0d]", k), int'(clkout1), k % 2);
    end
    step1(1'b1);
    chk("s1_midreset", int'(clkout1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
